// File: rtl/tftp_rx_mem_write.sv
// rtl/tftp_rx_mem_write.sv - TFTP DATA packet receiver writing payload into a BlockRAM image
//
// Parses incoming TFTP DATA packets (00 03 blk_hi blk_lo payload...), writes the
// payload at (block-1)*BLOCK_BYTES + offset and posts {block, length} as an ACK request.
// Optional feature macro: TFTP_RX_DUP_FILTER_EN (in-order block tracking, duplicate suppression).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready   packet byte stream from the UDP layer
//   ack_valid/ack_data/ack_ready        ACK request {block[31:16], length[15:0]}
//   err                    one-cycle pulse when a packet is dropped
//   rd_en/rd_addr/rd_data  registered read port of the image RAM (1-cycle latency)
module tftp_rx_mem_write #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 16,
    parameter int BLOCK_BYTES   = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     ack_valid,
    output logic [31:0]              ack_data,
    input  logic                     ack_ready,
    output logic                     err,
    input  logic                     rd_en,
    input  logic [RAM_ADDR_BITS-1:0] rd_addr,
    output logic [RAM_WIDTH-1:0]     rd_data
);

    localparam int MAX_BLOCK = (2 ** RAM_ADDR_BITS) / BLOCK_BYTES;

    typedef enum logic [2:0] {
        S_IDLE, S_OP_LO, S_BLK_HI, S_BLK_LO, S_DATA, S_ACK, S_DROP
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [15:0]              r_block;
    logic [9:0]               r_count;
    logic                     r_err;
    logic [31:0]              r_ack_data;
    logic                     r_dup;
    logic [RAM_WIDTH-1:0]     r_rd_data;
    logic [RAM_WIDTH-1:0]     r_mem [0:(2**RAM_ADDR_BITS)-1];

    logic                     w_beat;
    logic [15:0]              w_blk_full;
    logic                     w_blk_ok;
    logic                     w_blk_dup;
    logic                     w_we;
    logic                     w_err;
    logic                     w_ack_load;
    logic [31:0]              w_ack_word;
    logic [RAM_ADDR_BITS-1:0] w_wr_addr;
    logic                     w_count_full;

    assign in_ready  = !reset && (r_state != S_ACK);
    assign ack_valid = (r_state == S_ACK);
    assign ack_data  = r_ack_data;
    assign err       = r_err;
    assign rd_data   = r_rd_data;

    assign w_beat       = in_valid && in_ready;
    assign w_blk_full   = {r_block[15:8], in_data};
    assign w_count_full = (r_count == 10'(BLOCK_BYTES));
    assign w_wr_addr    = RAM_ADDR_BITS'((32'(r_block) - 32'd1) * 32'(BLOCK_BYTES) + 32'(r_count));

`ifdef TFTP_RX_DUP_FILTER_EN
    logic [15:0] r_expected;

    // Blocks ahead of the expected one are dropped; older ones are re-ACKed without writing.
    assign w_blk_ok  = (w_blk_full != 16'd0) && (w_blk_full <= 16'(MAX_BLOCK))
                       && (w_blk_full <= r_expected);
    assign w_blk_dup = (w_blk_full < r_expected);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected <= 16'd1;
        end else if (r_state == S_ACK && ack_ready && !r_dup) begin
            r_expected <= r_expected + 16'd1;
        end
    end
`else
    assign w_blk_ok  = (w_blk_full != 16'd0) && (w_blk_full <= 16'(MAX_BLOCK));
    assign w_blk_dup = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_err        = 1'b0;
        w_ack_load   = 1'b0;
        w_ack_word   = 32'd0;
        case (r_state)
            S_IDLE: if (w_beat) begin
                if (in_last)              begin w_err = 1'b1; w_next_state = S_IDLE; end
                else if (in_data != 8'h00) w_next_state = S_DROP;
                else                       w_next_state = S_OP_LO;
            end
            S_OP_LO: if (w_beat) begin
                if (in_last)              begin w_err = 1'b1; w_next_state = S_IDLE; end
                else if (in_data != 8'h03) w_next_state = S_DROP;
                else                       w_next_state = S_BLK_HI;
            end
            S_BLK_HI: if (w_beat) begin
                if (in_last) begin w_err = 1'b1; w_next_state = S_IDLE; end
                else               w_next_state = S_BLK_LO;
            end
            S_BLK_LO: if (w_beat) begin
                if (!w_blk_ok) begin
                    if (in_last) begin w_err = 1'b1; w_next_state = S_IDLE; end
                    else               w_next_state = S_DROP;
                end else if (in_last) begin
                    // header-only packet: acknowledge with zero length
                    w_ack_load   = 1'b1;
                    w_ack_word   = {w_blk_full, 16'd0};
                    w_next_state = S_ACK;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: if (w_beat) begin
                if (w_count_full) begin
                    // oversize payload: stop writing, discard the rest
                    if (in_last) begin w_err = 1'b1; w_next_state = S_IDLE; end
                    else               w_next_state = S_DROP;
                end else begin
                    w_we = !r_dup;
                    if (in_last) begin
                        w_ack_load   = 1'b1;
                        w_ack_word   = {r_block, 6'd0, r_count + 10'd1};
                        w_next_state = S_ACK;
                    end
                end
            end
            S_ACK: if (ack_ready) w_next_state = S_IDLE;
            S_DROP: if (w_beat && in_last) begin
                w_err        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_block    <= 16'd0;
            r_count    <= 10'd0;
            r_err      <= 1'b0;
            r_ack_data <= 32'd0;
            r_dup      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err;
            if (w_ack_load) r_ack_data <= w_ack_word;
            if (w_beat) begin
                case (r_state)
                    S_BLK_HI: r_block[15:8] <= in_data;
                    S_BLK_LO: begin
                        r_block <= w_blk_full;
                        r_count <= 10'd0;
                        r_dup   <= w_blk_dup;
                    end
                    S_DATA: if (!w_count_full) r_count <= r_count + 10'd1;
                    default: ;
                endcase
            end
        end
    end

    // Image RAM is not reset so it can map onto BlockRAM and survive a soft reset.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wr_addr] <= RAM_WIDTH'(in_data);
    end

    // Read-first: a same-cycle write to rd_addr returns the old contents.
    always_ff @(posedge clk) begin
        if (reset)      r_rd_data <= '0;
        else if (rd_en) r_rd_data <= r_mem[rd_addr];
    end

endmodule
